dbus_vmem_fifo_arb: RTL

Multi-core write arbiter for the video memory. It sits between the per-core data buses and the single write port of `vmem`. Each core gets its own request FIFO, so a core stalls only when its queue is full, not on every store. A round-robin arbiter drains one queued write per cycle into a registered vmem write port, and an idle flag reports when all queued writes have landed.

---
 rtl/dbus_vmem_fifo_arb_pkg.sv | 11 +
 rtl/vmem_req_fifo.sv | 59 +++++
 rtl/dbus_vmem_fifo_arb.sv | 109 ++++++++++
 3 files changed

// File: rtl/dbus_vmem_fifo_arb_pkg.sv
// Shared constants and helpers for the multi-core vmem write arbiter.
package dbus_vmem_fifo_arb_pkg;

    localparam int unsigned BUS_W = 32;

    // Reduce an index known to be below 2*n back into 0..n-1.
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/vmem_req_fifo.sv
// Per-core request queue: power-of-2 depth, naturally wrapping pointers, occupancy count.
module vmem_req_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dbus_vmem_fifo_arb.sv
// Multi-core vmem write arbiter: per-core request FIFOs drained round-robin,
// one write per cycle, into a registered vmem write port.
`ifndef NCORES
`define NCORES 4
`endif
`ifndef VMEM_ADDRW
`define VMEM_ADDRW 16
`endif
`ifndef DBUS_VMEM_DEPTH
`define DBUS_VMEM_DEPTH 4
`endif

module dbus_vmem_fifo_arb
    import dbus_vmem_fifo_arb_pkg::*;
#(
    parameter int unsigned NCORES = `NCORES,
    parameter int unsigned ADDRW  = `VMEM_ADDRW,
    parameter int unsigned PIXW   = 3,
    parameter int unsigned DEPTH  = `DBUS_VMEM_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NCORES-1:0]         we_packed_i,
    input  logic [BUS_W*NCORES-1:0]   addr_packed_i,
    input  logic [BUS_W*NCORES-1:0]   wdata_packed_i,
    output logic [NCORES-1:0]         stall_packed_o,
    output logic                      vmem_we_o,
    output logic [ADDRW-1:0]          vmem_waddr_o,
    output logic [PIXW-1:0]           vmem_wdata_o,
    output logic                      idle_o
);

    localparam int unsigned EW = ADDRW + PIXW;
    localparam int unsigned CW = (NCORES > 1) ? $clog2(NCORES) : 1;

    logic [NCORES-1:0] req;
    logic [NCORES-1:0] push;
    logic [NCORES-1:0] pop;
    logic [NCORES-1:0] full;
    logic [NCORES-1:0] empty;
    logic [EW-1:0]     head [NCORES];

    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     rr_next;
    logic [CW-1:0]     grant_idx;
    logic              grant;

    // Only the low PIXW data bits are stored.
    logic unused_wdata;
    assign unused_wdata = ^wdata_packed_i;

    for (genvar i = 0; i < NCORES; i++) begin : g_core
        // Address 0 doubles as "no request"; a write enable is also required.
        assign req[i]  = we_packed_i[i] && (addr_packed_i[BUS_W*i +: BUS_W] != '0);
        assign push[i] = req[i] && !full[i];

        vmem_req_fifo #(
            .W     (EW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   ({addr_packed_i[BUS_W*i +: ADDRW], wdata_packed_i[BUS_W*i +: PIXW]}),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    assign stall_packed_o = full;

    // Round-robin search upward from rr_ptr for the first non-empty FIFO.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = 1'b0;
        grant_idx = '0;
        pop       = '0;
        for (int unsigned off = 0; off < NCORES; off++) begin
            idx = rr_wrap(32'(rr_ptr) + off, NCORES);
            if (!grant && !empty[CW'(idx)]) begin
                grant     = 1'b1;
                grant_idx = CW'(idx);
            end
        end
        pop[grant_idx] = grant;
        rr_next        = CW'(rr_wrap(32'(grant_idx) + 1, NCORES));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr       <= '0;
            vmem_we_o    <= 1'b0;
            vmem_waddr_o <= '0;
            vmem_wdata_o <= '0;
            idle_o       <= 1'b1;
        end else begin
            vmem_we_o <= grant;
            if (grant) begin
                rr_ptr                        <= rr_next;
                {vmem_waddr_o, vmem_wdata_o}  <= head[grant_idx];
            end
            idle_o <= (&empty) && !grant && !(|push);
        end
    end

endmodule
